// File: rtl/button_reset_pkg.sv
// Shared types and defaults for the push-button soft reset generator.
// Controller states and default timing constants live here.
package button_reset_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HOLD     = 3'd2,
        WAIT_REL = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_HOLD_CYCLES     = 500;
    localparam int DEF_CNT_W           = 18;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs.
// Both flops clear to 0 on synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_reset_gen.sv
// Debounces a raw push-button and emits one fixed-length soft reset
// pulse per accepted press, plus the debounced button level.
module button_reset_gen
    import button_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic soft_reset,
    output logic press_pulse,
    output logic btn_level,
    output logic busy
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        (64'd1 << CNT_W) <= 64'(HOLD_CYCLES)) begin : g_bad_w
        $error("CNT_W too narrow for the terminal counts");
    end

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic             btn_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .q     (btn_s)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (btn_s) begin
                    state_n = PRESS_DB;
                    cnt_n   = ONE;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            // Button is ignored while holding so the pulse length is fixed.
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = WAIT_REL;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            WAIT_REL: begin
                cnt_n = '0;
                if (!btn_s) begin
                    state_n = REL_DB;
                    cnt_n   = ONE;
                end
            end
            REL_DB: begin
                if (btn_s) begin
                    state_n = WAIT_REL;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs decode next-state so they move on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            soft_reset  <= 1'b0;
            press_pulse <= 1'b0;
            btn_level   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            soft_reset  <= (state_n == HOLD);
            press_pulse <= (state_n == HOLD) && (state != HOLD);
            btn_level   <= (state_n == HOLD) || (state_n == WAIT_REL) ||
                           (state_n == REL_DB);
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_button_reset_gen.sv
// Self-checking bench for button_reset_gen: vector table, directed
// corner sequences and random button activity against a run-length model.
module tb_button_reset_gen;

    localparam int DB = 8;
    localparam int HO = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn = 1'b0;
    logic soft_reset, press_pulse, btn_level, busy;

    always #20 clk = ~clk;

    button_reset_gen #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HO),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .soft_reset  (soft_reset),
        .press_pulse (press_pulse),
        .btn_level   (btn_level),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tick_no  = 0;

    // Reference: two-sample delay line, then phases driven by run lengths
    // of consecutive equal samples (0 idle/arming, 1 pulsing, 2 releasing).
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    int   m_phase = 0, m_run = 0, m_held = 0;

    // Pulse monitor
    logic prev_soft = 1'b0, prev_busy = 1'b0;
    int   npulse = 0, plen = 0, last_len = 0;
    int   last_rise = 0, last_fall = 0, busy_rises = 0, level_hits = 0;

    typedef struct {
        logic       b;
        logic       r;
        logic [3:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)",
                     name, act, exp, tick_no);
        end
    endtask

    task automatic model_step(input logic r, input logic b_in);
        logic b;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0;
            m_phase = 0; m_run = 0; m_held = 0;
        end else begin
            b = m_s2;
            m_s2 = m_s1;
            m_s1 = b_in;
            case (m_phase)
                0: begin
                    m_run = b ? m_run + 1 : 0;
                    if (m_run == DB) begin
                        m_phase = 1; m_held = 0; m_run = 0;
                    end
                end
                1: begin
                    m_held++;
                    if (m_held == HO) begin
                        m_phase = 2; m_run = 0;
                    end
                end
                default: begin
                    m_run = b ? 0 : m_run + 1;
                    if (m_run == DB) begin
                        m_phase = 0; m_run = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic tick(input logic b, input logic r);
        btn = b;
        reset = r;
        @(posedge clk);
        model_step(r, b);
        #1;
        tick_no++;
        check("soft_reset", soft_reset, m_phase == 1);
        check("press_pulse", press_pulse, m_phase == 1 && m_held == 0);
        check("btn_level", btn_level, m_phase != 0);
        check("busy", busy, m_phase != 0 || m_run > 0);
        if (soft_reset && !prev_soft) begin
            npulse++; plen = 0; last_rise = tick_no;
        end
        if (soft_reset) plen++;
        if (!soft_reset && prev_soft) begin
            last_len = plen; last_fall = tick_no;
        end
        if (busy && !prev_busy) busy_rises++;
        if (btn_level) level_hits++;
        prev_soft = soft_reset;
        prev_busy = busy;
    endtask

    task automatic clear_mon();
        npulse = 0; last_len = 0; busy_rises = 0; level_hits = 0;
    endtask

    vec_t vt[19];
    int   k, found, rise1, fall1;
    logic seg_v;
    int   seg_n;

    initial begin
        // Test 1 table: 3 reset rows with btn high, then release.
        // exp = {soft_reset, press_pulse, btn_level, busy}
        for (int i = 0; i < 19; i++) begin
            vt[i].b = 1'b1;
            vt[i].r = (i < 3);
            if (i < 5)       vt[i].exp = 4'b0000;
            else if (i < 12) vt[i].exp = 4'b0001;
            else if (i == 12) vt[i].exp = 4'b1111;
            else if (i < 17) vt[i].exp = 4'b1011;
            else             vt[i].exp = 4'b0011;
        end

        btn = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        clear_mon();
        for (int i = 0; i < 19; i++) begin
            tick(vt[i].b, vt[i].r);
            check("t1_vec", {soft_reset, press_pulse, btn_level, busy},
                  vt[i].exp);
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
        check("t1_npulse", npulse, 1);
        check("t1_len", last_len, HO);

        // Test 2: 7-cycle glitches never qualify.
        clear_mon();
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        check("t2_npulse", npulse, 0);
        check("t2_busy_toggles", busy_rises, 4);
        check("t2_level", level_hits, 0);

        // Test 3: long hold gives one pulse; level drops 2+8 after release.
        clear_mon();
        for (int i = 0; i < 200; i++) tick(1'b1, 1'b0);
        found = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            if (found < 0 && !btn_level) found = i;
        end
        check("t3_npulse", npulse, 1);
        check("t3_len", last_len, HO);
        check("t3_level_fall", found, 9);
        check("t3_busy_end", busy, 0);

        // Test 4: release bounce returns to waiting; no second pulse.
        clear_mon();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
        found = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            if (found < 0 && !btn_level) found = i;
        end
        check("t4_npulse", npulse, 1);
        check("t4_level_fall", found, 9);

        // Test 5: reset in the 3rd soft_reset cycle aborts the pulse.
        clear_mon();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1'b1, 1'b0);
            if (soft_reset) found = 1;
        end
        check("t5_first_rise", found, 1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("t5_abort_soft", soft_reset, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_len", last_len, 3);
        found = -1;
        for (int i = 0; i < 30 && found < 0; i++) begin
            tick(1'b1, 1'b0);
            if (soft_reset) found = i;
        end
        check("t5_rearm_rise", found, 9);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b0);
        check("t5_rearm_len", last_len, HO);
        check("t5_npulse", npulse, 2);

        // Test 6: two clean presses.
        clear_mon();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
        check("t6_len1", last_len, HO);
        rise1 = last_rise;
        fall1 = last_fall;
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
        check("t6_npulse", npulse, 2);
        check("t6_len2", last_len, HO);
        check("t6_gap_ok", (last_rise - fall1) >= 2 * DB, 1);
        check("t6_rise_order", last_rise > rise1, 1);

        // Random bursts with occasional resets, checked every cycle.
        k = 0;
        while (k < 3000) begin
            seg_v = 1'($urandom_range(0, 1));
            seg_n = $urandom_range(1, 14);
            for (int i = 0; i < seg_n; i++) begin
                tick(seg_v, $urandom_range(0, 199) == 0);
                k++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
